// File: rtl/bandgap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bandgap_ctrl_pkg
// Shared definitions for the bandgap enable sequencer:
//   - 3-bit state encoding (IDLE/SETTLE/READY/COOLDOWN/CHECK/FAULT)
//   - default cycle counts and counter width
//   - small decode helpers used to derive the registered status outputs
// CHECK and FAULT are only reachable when BGCTRL_OKCHK_EN is defined.
// -----------------------------------------------------------------------------
package bandgap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_READY    = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_CHECK    = 3'd4,
    ST_FAULT    = 3'd5
  } bg_state_e;

  localparam int unsigned SETTLE_CYCLES_DEFAULT  = 1000;
  localparam int unsigned OFF_CYCLES_DEFAULT     = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 4096;
  localparam int unsigned CNT_W_DEFAULT          = 16;

  // Bandgap EN is held in every state where the reference is powered
  // (FAULT deliberately switches it off).
  function automatic logic state_en(bg_state_e s);
    return (s == ST_SETTLE) || (s == ST_CHECK) || (s == ST_READY);
  endfunction

  function automatic logic state_busy(bg_state_e s);
    return (s == ST_SETTLE) || (s == ST_CHECK) || (s == ST_COOLDOWN);
  endfunction

endpackage

// File: rtl/bgctrl_sync2.sv
// -----------------------------------------------------------------------------
// bgctrl_sync2
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset; both flops clear to 0
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two clk_i edges of latency
// -----------------------------------------------------------------------------
module bgctrl_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bandgap_en_ctrl.sv
// -----------------------------------------------------------------------------
// bandgap_en_ctrl
// Power-up sequencer in front of the bandgap reference cell. Converts a
// level request into the bandgap EN signal, holds off READY until a settle
// time has elapsed and enforces a minimum EN-low time after every disable.
//
// Optional feature macro: BGCTRL_OKCHK_EN
//   Adds vbgp_ok_i / fault_o. After settling the sequencer waits (CHECK)
//   for the synchronized window-comparator flag; a timeout or a later loss
//   of the flag while READY parks the block in FAULT with EN off.
//
// Ports:
//   wb_clk_i  - system clock (only clock)
//   wb_rst_n  - asynchronous active-low reset
//   req_i     - bandgap on-request, level, synchronous to wb_clk_i
//   vbgp_ok_i - (BGCTRL_OKCHK_EN) asynchronous reference-good flag
//   fault_o   - (BGCTRL_OKCHK_EN) registered fault status
//   en_o      - registered bandgap EN
//   ready_o   - registered reference-valid status
//   busy_o    - registered, high while settling/checking/cooling down
// -----------------------------------------------------------------------------
module bandgap_en_ctrl
  import bandgap_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEFAULT,
  parameter int unsigned OFF_CYCLES     = OFF_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = CNT_W_DEFAULT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n,
  input  logic req_i,
`ifdef BGCTRL_OKCHK_EN
  input  logic vbgp_ok_i,
  output logic fault_o,
`endif
  output logic en_o,
  output logic ready_o,
  output logic busy_o
);

  // Reject cycle counts that are zero or whose reload value does not fit
  // the shared counter.
  if ((SETTLE_CYCLES < 1) || (((SETTLE_CYCLES - 1) >> CNT_W) != 0) ||
      (OFF_CYCLES < 1)    || (((OFF_CYCLES - 1) >> CNT_W) != 0) ||
      (TIMEOUT_CYCLES < 1) || (((TIMEOUT_CYCLES - 1) >> CNT_W) != 0))
  begin : g_bad_params
    $error("bandgap_en_ctrl: cycle parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_CYCLES - 1);

  bg_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, ready_q, busy_q;
  logic             en_d, ready_d, busy_d;

`ifdef BGCTRL_OKCHK_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic ok_s;
  logic fault_q, fault_d;

  bgctrl_sync2 u_ok_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n),
    .d_i    (vbgp_ok_i),
    .q_o    (ok_s)
  );
`endif

  // State, counter and output registers. Outputs are registered copies of
  // the decode of state_d so they are glitch-free and change on the same
  // edge as the state.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BGCTRL_OKCHK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef BGCTRL_OKCHK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Next-state logic. A dropped request always wins over counter expiry so
  // the cooldown is never skipped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d = ST_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!req_i) begin
          state_d = ST_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end else if (cnt_q == '0) begin
`ifdef BGCTRL_OKCHK_EN
          state_d = ST_CHECK;
          cnt_d   = TIMEOUT_LOAD;
`else
          state_d = ST_READY;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READY: begin
        if (!req_i) begin
          state_d = ST_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end
`ifdef BGCTRL_OKCHK_EN
        else if (!ok_s) begin
          state_d = ST_FAULT;
        end
`endif
      end
      ST_COOLDOWN: begin
        // req_i is ignored here; a still-high request re-enters SETTLE
        // from IDLE one edge after the count expires.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef BGCTRL_OKCHK_EN
      ST_CHECK: begin
        if (!req_i) begin
          state_d = ST_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end else if (ok_s) begin
          state_d = ST_READY;
        end else if (cnt_q == '0) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (!req_i) begin
          state_d = ST_COOLDOWN;
          cnt_d   = OFF_LOAD;
        end
      end
`endif
      default: begin
        // Unused (or, without the feature, unreachable) encodings recover.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode of the next state, captured by the output registers.
  always_comb begin
    en_d    = state_en(state_d);
    ready_d = (state_d == ST_READY);
    busy_d  = state_busy(state_d);
`ifdef BGCTRL_OKCHK_EN
    fault_d = (state_d == ST_FAULT);
`endif
  end

  assign en_o    = en_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
`ifdef BGCTRL_OKCHK_EN
  assign fault_o = fault_q;
`endif

endmodule

// File: tb/tb_bandgap_en_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bandgap_en_ctrl
// Self-checking bench for bandgap_en_ctrl (SETTLE=8, OFF=4, TIMEOUT=16).
// Directed scenarios use closed-form edge arithmetic; the random scenario
// uses a timestamp model (when EN came on, when cooldown ends).
// Define BGCTRL_OKCHK_EN to also exercise the reference-good check.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bandgap_en_ctrl;

  localparam int SETTLE  = 8;
  localparam int OFF     = 4;
  localparam int TIMEOUT = 16;
`ifdef BGCTRL_OKCHK_EN
  // With vbgp_ok already good, CHECK lasts exactly one edge.
  localparam int CHECK_EXTRA = 1;
`else
  localparam int CHECK_EXTRA = 0;
`endif
  localparam int ON_DELAY = SETTLE + CHECK_EXTRA;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic req   = 1'b0;
  logic en, ready, busy;
`ifdef BGCTRL_OKCHK_EN
  logic vbgp_ok = 1'b1;
  logic fault;
`endif

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;

  // Reference model: EN on/off plus timestamps.
  bit m_on;
  int m_on_edge;
  int m_cool_until;
  bit exp_en, exp_ready, exp_busy;

  bandgap_en_ctrl #(
    .SETTLE_CYCLES  (SETTLE),
    .OFF_CYCLES     (OFF),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .req_i     (req),
`ifdef BGCTRL_OKCHK_EN
    .vbgp_ok_i (vbgp_ok),
    .fault_o   (fault),
`endif
    .en_o      (en),
    .ready_o   (ready),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, edge=%0d", edge_no);
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_on         = 1'b0;
    m_on_edge    = 0;
    m_cool_until = -1;
    exp_en       = 1'b0;
    exp_ready    = 1'b0;
    exp_busy     = 1'b0;
  endtask

  // Advance the model by one sampled edge e with request level r.
  task automatic model_edge(input logic r, input int e);
    if (m_on) begin
      if (!r) begin
        m_on         = 1'b0;
        m_cool_until = e + OFF;   // IDLE is reached after this edge
      end
    end else if (r && (e > m_cool_until)) begin
      m_on      = 1'b1;
      m_on_edge = e;
    end
    exp_en    = m_on;
    exp_ready = m_on && ((e - m_on_edge) >= ON_DELAY);
    exp_busy  = (m_on && !exp_ready) || (e < m_cool_until);
  endtask

  // Drive req for one edge, update the model, sample 1 ns after the edge.
  task automatic step(input logic r);
    req = r;
    @(posedge clk);
    edge_no++;
    model_edge(r, edge_no);
    #1;
  endtask

  task automatic go_idle();
    for (int i = 0; i < OFF + 2; i++) step(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b1;
    model_reset();
    #2;
    checks++; if (en !== 1'b0)    begin failures++; $display("FAIL reset_en: en_o=%b expected 0", en); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: ready_o=%b expected 0", ready); end
    checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL reset_busy: busy_o=%b expected 0", busy); end
    repeat (3) @(posedge clk);
    edge_no += 3;
    #1;
    checks++; if (en !== 1'b0) begin failures++; $display("FAIL reset_held_en: en_o=%b expected 0 with req high", en); end
    req   = 1'b0;
    rst_n = 1'b1;
    $display("test_reset: reset released at edge %0d", edge_no);
  endtask

  task automatic test_power_up();
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      checks++; if ({en, ready, busy} !== 3'b000) begin failures++; $display("FAIL idle_outputs: en/ready/busy=%b expected 000", {en, ready, busy}); end
    end
    for (int j = 0; j <= ON_DELAY + 2; j++) begin
      step(1'b1);
      checks++; if (en !== 1'b1) begin failures++; $display("FAIL pu_en j=%0d: en_o=%b expected 1", j, en); end
      checks++; if (ready !== (j >= ON_DELAY)) begin failures++; $display("FAIL pu_ready j=%0d: ready_o=%b expected %b", j, ready, (j >= ON_DELAY)); end
      checks++; if (busy !== (j < ON_DELAY)) begin failures++; $display("FAIL pu_busy j=%0d: busy_o=%b expected %b", j, busy, (j < ON_DELAY)); end
    end
    $display("test_power_up: ready after %0d edges", ON_DELAY);
  endtask

  // From READY: drop req at j=0, raise it again at j=1; re-enable at OFF+1.
  task automatic test_disable_cooldown();
    for (int j = 0; j <= OFF + 2; j++) begin
      step(j != 0);
      checks++; if (en !== (j >= OFF + 1)) begin failures++; $display("FAIL cd_en j=%0d: en_o=%b expected %b", j, en, (j >= OFF + 1)); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL cd_ready j=%0d: ready_o=%b expected 0", j, ready); end
      checks++; if (busy !== ((j < OFF) || (j >= OFF + 1))) begin failures++; $display("FAIL cd_busy j=%0d: busy_o=%b expected %b", j, busy, ((j < OFF) || (j >= OFF + 1))); end
    end
    $display("test_disable_cooldown: re-enable after %0d edges", OFF + 1);
  endtask

  task automatic test_abort_settle();
    go_idle();
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int j = 0; j <= OFF + 1; j++) begin
      step(1'b0);
      checks++; if ({en, ready} !== 2'b00) begin failures++; $display("FAIL abort_en_ready j=%0d: en/ready=%b expected 00", j, {en, ready}); end
      checks++; if (busy !== (j < OFF)) begin failures++; $display("FAIL abort_busy j=%0d: busy_o=%b expected %b", j, busy, (j < OFF)); end
    end
    $display("test_abort_settle: cooldown %0d edges, ready never seen", OFF);
  endtask

  task automatic test_async_reset();
    go_idle();
    for (int i = 0; i < 5; i++) step(1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (en !== 1'b0)   begin failures++; $display("FAIL areset_en: en_o=%b expected 0 before next edge", en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy: busy_o=%b expected 0", busy); end
    @(posedge clk);
    edge_no++;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int j = 0; j <= ON_DELAY + 1; j++) begin
      step(1'b1);
      checks++; if (en !== 1'b1) begin failures++; $display("FAIL ar_en j=%0d: en_o=%b expected 1", j, en); end
      checks++; if (ready !== (j >= ON_DELAY)) begin failures++; $display("FAIL ar_ready j=%0d: ready_o=%b expected %b", j, ready, (j >= ON_DELAY)); end
    end
    $display("test_async_reset: full settle repeated after reset");
  endtask

  task automatic test_random();
    int seg_len;
    logic r;
    go_idle();
    r = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      r       = ~r;
      seg_len = $urandom_range(1, 14);
      $display("test_random: segment %0d req=%b len=%0d", seg, r, seg_len);
      for (int i = 0; i < seg_len; i++) begin
        step(r);
        checks++; if (en !== exp_en)       begin failures++; $display("FAIL rnd_en edge=%0d: en_o=%b expected %b", edge_no, en, exp_en); end
        checks++; if (ready !== exp_ready) begin failures++; $display("FAIL rnd_ready edge=%0d: ready_o=%b expected %b", edge_no, ready, exp_ready); end
        checks++; if (busy !== exp_busy)   begin failures++; $display("FAIL rnd_busy edge=%0d: busy_o=%b expected %b", edge_no, busy, exp_busy); end
`ifdef BGCTRL_OKCHK_EN
        checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rnd_fault edge=%0d: fault_o=%b expected 0", edge_no, fault); end
`endif
      end
    end
  endtask

`ifdef BGCTRL_OKCHK_EN
  // vbgp_ok never good: CHECK times out TIMEOUT edges after settle expiry.
  task automatic test_check_timeout();
    go_idle();
    vbgp_ok = 1'b0;
    for (int j = 0; j <= SETTLE + TIMEOUT + 1; j++) begin
      step(1'b1);
      checks++; if (fault !== (j >= SETTLE + TIMEOUT)) begin failures++; $display("FAIL to_fault j=%0d: fault_o=%b expected %b", j, fault, (j >= SETTLE + TIMEOUT)); end
      checks++; if (en !== (j < SETTLE + TIMEOUT)) begin failures++; $display("FAIL to_en j=%0d: en_o=%b expected %b", j, en, (j < SETTLE + TIMEOUT)); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL to_ready j=%0d: ready_o=%b expected 0", j, ready); end
    end
    step(1'b0);
    checks++; if ({en, fault, busy} !== 3'b001) begin failures++; $display("FAIL to_clear: en/fault/busy=%b expected 001", {en, fault, busy}); end
    $display("test_check_timeout: fault after %0d edges, cleared by req low", SETTLE + TIMEOUT);
  endtask

  // vbgp_ok rises after edge SETTLE+2; two sync flops plus the state
  // register put READY after edge SETTLE+5. Then losing it gives FAULT.
  task automatic test_ok_late();
    go_idle();
    vbgp_ok = 1'b0;
    for (int j = 0; j <= SETTLE + 6; j++) begin
      if (j == SETTLE + 3) vbgp_ok = 1'b1;
      step(1'b1);
      checks++; if (ready !== (j >= SETTLE + 5)) begin failures++; $display("FAIL ok_ready j=%0d: ready_o=%b expected %b", j, ready, (j >= SETTLE + 5)); end
      checks++; if (en !== 1'b1) begin failures++; $display("FAIL ok_en j=%0d: en_o=%b expected 1", j, en); end
    end
    vbgp_ok = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step(1'b1);
      checks++; if (fault !== (j == 2)) begin failures++; $display("FAIL loss_fault j=%0d: fault_o=%b expected %b", j, fault, (j == 2)); end
      checks++; if (ready !== (j != 2)) begin failures++; $display("FAIL loss_ready j=%0d: ready_o=%b expected %b", j, ready, (j != 2)); end
    end
    step(1'b0);
    vbgp_ok = 1'b1;
    go_idle();
    $display("test_ok_late: ready via synchronizer, fault on loss");
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_power_up();
    test_disable_cooldown();
    test_abort_settle();
    test_async_reset();
    test_random();
`ifdef BGCTRL_OKCHK_EN
    test_check_timeout();
    test_ok_late();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
